imem_loader: RTL and testbench

- Boot-time program loader that streams a byte-serial image from a host link (UART/SPI bridge) into instruction_memory through its write port (addr/din/we).
- Holds the core in reset (core_run low) while a load is in progress and releases it once the image is complete.
- Sits between the host byte-stream front end and instruction_memory.
- It is the only agent that drives the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_to_word_assembler.sv | 35 +++
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_to_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; flags the 4th byte of each word.
module byte_to_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [BYTE_W-1:0] i_data,
  output logic [WORD_W-1:0] o_word_c,
  output logic              o_word_valid_c
);

  localparam int unsigned      CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0]         r_cnt;
  logic [WORD_W-BYTE_W-1:0] r_buf;

  // The top byte is never stored; it is taken straight from the input on the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_buf <= '0;
    end else if (i_valid) begin
      r_cnt <= r_cnt + CNT_W'(1);
      for (int unsigned k = 0; k < BYTES_PER_WORD - 1; k++) begin
        if (r_cnt == CNT_W'(k)) r_buf[k*BYTE_W +: BYTE_W] <= i_data;
      end
    end
  end

  assign o_word_c       = {i_data, r_buf};
  assign o_word_valid_c = i_valid && (r_cnt == LAST);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the core in reset until done.
// Optional trailing checksum word enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          AUTOSTART = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_din,
  output logic              imem_we,
  output logic              core_run,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DEPTH-2:0]  words_loaded
);

  localparam int unsigned WL_W      = DEPTH - 1;
  localparam int unsigned CAP_WORDS = 1 << (DEPTH - 2);
  localparam state_t      RST_STATE = AUTOSTART ? LEN : IDLE;

  state_t            r_state;
  state_t            w_next;
  logic              w_fire;
  logic [WORD_W-1:0] w_word;
  logic              w_word_valid;
  logic              w_start_ok;
  logic              w_load_len;
  logic              w_write;
  logic              w_last;
  logic [WL_W-1:0]   r_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] r_sum;
`endif

  assign s_ready = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
  assign w_fire  = s_valid && s_ready;
  assign w_last  = (words_loaded + WL_W'(1)) == r_len;

  byte_to_word_assembler u_asm (
    .clk            (clk),
    .rst_n          (reset),
    .i_valid        (w_fire),
    .i_data         (s_data),
    .o_word_c       (w_word),
    .o_word_valid_c (w_word_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RST_STATE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start_ok = 1'b0;
    w_load_len = 1'b0;
    w_write    = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          w_next     = LEN;
          w_start_ok = 1'b1;
        end
      end
      LEN: begin
        if (w_word_valid) begin
          if ((w_word == '0) || (w_word > CAP_WORDS)) begin
            w_next = ERROR;
          end else begin
            w_next     = DATA;
            w_load_len = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_word_valid) begin
          w_write = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (w_last) w_next = CSUM;
`else
          if (w_last) w_next = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (w_word_valid) w_next = (w_word == r_sum) ? DONE : ERROR;
      end
`endif
      default: w_next = RST_STATE;
    endcase
  end

  // Write port and word count; address/data hold between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_din     <= '0;
      words_loaded <= '0;
      r_len        <= '0;
    end else begin
      imem_we <= w_write;
      if (w_write) begin
        imem_addr    <= BASE_ADDR + (32'(words_loaded) << 2);
        imem_din     <= w_word;
        words_loaded <= words_loaded + WL_W'(1);
      end else if (w_start_ok) begin
        words_loaded <= '0;
      end
      if (w_load_len) r_len <= WL_W'(w_word);
    end
  end

  // Status flags follow the state being entered so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      core_run <= 1'b0;
    end else begin
      busy     <= (w_next == LEN) || (w_next == DATA) || (w_next == CSUM);
      done     <= (w_next == DONE);
      error    <= (w_next == ERROR);
      core_run <= (w_next == DONE);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else if ((w_next == LEN) && (r_state != LEN)) begin
      r_sum <= '0;
    end else if (w_write) begin
      r_sum <= r_sum + w_word;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (DEPTH=12, BASE_ADDR=0, AUTOSTART=1).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;
  logic        imem_we;
  logic        core_run;
  logic        busy;
  logic        done;
  logic        error;
  logic [10:0] words_loaded;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_din[$];
  logic [31:0] last_sum;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(12), .BASE_ADDR(32'h0), .AUTOSTART(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .imem_addr    (imem_addr),
    .imem_din     (imem_din),
    .imem_we      (imem_we),
    .core_run     (core_run),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // Write-port log
  always @(negedge clk) begin
    if (reset && imem_we) begin
      q_addr.push_back(imem_addr);
      q_din.push_back(imem_din);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    s_data  = b;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic send_csum(input logic [31:0] s);
    last_sum = s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(last_sum);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_din.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(2);
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", imem_we); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    checks++; if (imem_din !== 32'h0) begin errors++; $display("FAIL rst_din got %h exp 0", imem_din); end
    checks++; if ({core_run, busy, done, error} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags got %b exp 0000", {core_run, busy, done, error});
    end
    checks++; if (words_loaded !== 11'd0) begin errors++; $display("FAIL rst_words got %0d exp 0", words_loaded); end
    reset = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_autostart_ready got %b exp 1", s_ready); end
    idle(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_autostart_busy got %b exp 1", busy); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_w[3];
    exp_w[0] = 32'h0000_0013;
    exp_w[1] = 32'h0010_0093;
    exp_w[2] = 32'h0000_0073;
    clear_log();
    send_word(32'd3);
    for (int i = 0; i < 3; i++) send_word(exp_w[i]);
    send_csum(32'h0010_0119);
    idle(2);
    checks++; if (q_addr.size() != 3) begin errors++; $display("FAIL basic_we_count got %0d exp 3", q_addr.size()); end
    for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
      checks++; if (q_addr[i] !== 32'(4 * i)) begin errors++; $display("FAIL basic_addr%0d got %h exp %h", i, q_addr[i], 32'(4 * i)); end
      checks++; if (q_din[i] !== exp_w[i]) begin errors++; $display("FAIL basic_din%0d got %h exp %h", i, q_din[i], exp_w[i]); end
    end
    checks++; if (words_loaded !== 11'd3) begin errors++; $display("FAIL basic_words got %0d exp 3", words_loaded); end
    checks++; if ({done, core_run, busy, error, s_ready} !== 5'b11000) begin
      errors++; $display("FAIL basic_flags got %b exp 11000", {done, core_run, busy, error, s_ready});
    end
  endtask

  task automatic test_zero_len();
    pulse_start();
    checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL zl_core_drop got %b exp 0", core_run); end
    checks++; if ({busy, done, words_loaded} !== {1'b1, 1'b0, 11'd0}) begin
      errors++; $display("FAIL zl_restart got busy %b done %b words %0d exp 1 0 0", busy, done, words_loaded);
    end
    clear_log();
    send_word(32'd0);
    idle(2);
    checks++; if ({error, core_run, busy} !== 3'b100) begin
      errors++; $display("FAIL zl_error got %b exp 100", {error, core_run, busy});
    end
    checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL zl_no_we got %0d exp 0", q_addr.size()); end
    pulse_start();
    checks++; if ({busy, s_ready, error} !== 3'b110) begin
      errors++; $display("FAIL zl_restart2 got %b exp 110", {busy, s_ready, error});
    end
  endtask

  task automatic test_len_bounds();
    logic [31:0] sum;
    logic [31:0] w;
    clear_log();
    send_word(32'h0000_0401);
    idle(1);
    checks++; if ({error, done, busy} !== 3'b100) begin
      errors++; $display("FAIL len401 got %b exp 100", {error, done, busy});
    end
    checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL len401_no_we got %0d exp 0", q_addr.size()); end
    pulse_start();
    send_word(32'h0000_0400);
    sum = '0;
    for (int i = 0; i < 1024; i++) begin
      w = 32'hA500_0000 | 32'(i);
      sum = sum + w;
      send_word(w);
    end
    send_csum(sum);
    idle(2);
    checks++; if (q_addr.size() != 1024) begin errors++; $display("FAIL len400_we_count got %0d exp 1024", q_addr.size()); end
    if (q_addr.size() > 0) begin
      checks++; if (q_addr[q_addr.size()-1] !== 32'h0000_0FFC) begin
        errors++; $display("FAIL len400_last_addr got %h exp 00000ffc", q_addr[q_addr.size()-1]);
      end
      checks++; if (q_din[q_din.size()-1] !== 32'hA500_03FF) begin
        errors++; $display("FAIL len400_last_din got %h exp a50003ff", q_din[q_din.size()-1]);
      end
    end
    checks++; if ({done, core_run, words_loaded} !== {1'b1, 1'b1, 11'h400}) begin
      errors++; $display("FAIL len400_done got done %b run %b words %0d exp 1 1 1024", done, core_run, words_loaded);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] exp_w[2];
    logic [7:0]  bytes[12];
    exp_w[0] = 32'hDEAD_BEEF;
    exp_w[1] = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      bytes[k]     = (k == 0) ? 8'd2 : 8'd0;
      bytes[4 + k] = exp_w[0][8*k +: 8];
      bytes[8 + k] = exp_w[1][8*k +: 8];
    end
    pulse_start();
    clear_log();
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(0, 3));
      send_byte(bytes[i]);
      if (i == 7) begin
        checks++; if ({imem_we, words_loaded} !== {1'b1, 11'd1}) begin
          errors++; $display("FAIL gap_we_words got we %b words %0d exp 1 1", imem_we, words_loaded);
        end
      end
    end
    send_csum(exp_w[0] + exp_w[1]);
    idle(3);
    checks++; if (q_addr.size() != 2) begin errors++; $display("FAIL gap_we_count got %0d exp 2", q_addr.size()); end
    for (int i = 0; i < 2 && i < q_addr.size(); i++) begin
      checks++; if (q_addr[i] !== 32'(4 * i) || q_din[i] !== exp_w[i]) begin
        errors++; $display("FAIL gap_write%0d got %h/%h exp %h/%h", i, q_addr[i], q_din[i], 32'(4 * i), exp_w[i]);
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done got %b exp 1", done); end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send_word(32'd2);
    send_word(32'h1111_1111);
    send_byte(8'h22);
    reset = 1'b0;
    #1;
    checks++; if ({imem_we, core_run, busy, done, error} !== 5'b00000) begin
      errors++; $display("FAIL mid_rst_flags got %b exp 00000", {imem_we, core_run, busy, done, error});
    end
    checks++; if ({imem_addr, imem_din, words_loaded} !== {32'h0, 32'h0, 11'd0}) begin
      errors++; $display("FAIL mid_rst_regs got %h %h %0d exp 0 0 0", imem_addr, imem_din, words_loaded);
    end
    idle(1);
    reset = 1'b1;
    idle(1);
    clear_log();
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    send_csum(32'hCAFE_F00D);
    idle(2);
    checks++; if (q_addr.size() != 1 || (q_addr.size() == 1 && (q_addr[0] !== 32'h0 || q_din[0] !== 32'hCAFE_F00D))) begin
      errors++; $display("FAIL mid_reload got %0d writes exp 1 at 0 of cafef00d", q_addr.size());
    end
    checks++; if ({done, core_run} !== 2'b11) begin errors++; $display("FAIL mid_reload_done got %b exp 11", {done, core_run}); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_word(32'd2);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd3);
    idle(1);
    checks++; if ({done, core_run, error} !== 3'b110) begin
      errors++; $display("FAIL csum_good got %b exp 110", {done, core_run, error});
    end
    pulse_start();
    send_word(32'd2);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd4);
    idle(1);
    checks++; if ({done, core_run, error} !== 3'b001) begin
      errors++; $display("FAIL csum_bad got %b exp 001", {done, core_run, error});
    end
  endtask
`endif

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    last_sum = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_len_bounds();
    test_gaps();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
